eth_rxframe: RTL and testbench

- Downstream of the MII nibble-to-byte receive stage; consumes its byte stream (data, valid, error) on the same byte clock.
- Strips preamble/SFD, filters on destination address, computes Ethernet CRC-32, writes frame bytes into a single-frame packet RAM.
- Reports length and status to the host side through a done/ack handshake.

---
 rtl/eth_rxframe.sv | 177 +++++++++++++++++
 tb/tb_eth_rxframe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rxframe.sv
// Ethernet receive framer: preamble/SFD strip, address filter, CRC-32,
// single-frame packet RAM writer with done/ack host handshake.
module eth_rxframe #(
   parameter int AW     = 11,
   parameter int MAXLEN = 1518,
   parameter int MINLEN = 64
) (
   input  logic          rxclk_i,
   input  logic          rst_n,
   input  logic          rxdv_i,
   input  logic          rxer_i,
   input  logic [7:0]    dat_i,
   input  logic          ena_i,
   input  logic          promisc_i,
   input  logic [47:0]   mac_i,
   input  logic          ack_i,
   output logic          wr_o,
   output logic [AW-1:0] waddr_o,
   output logic [7:0]    wdat_o,
   output logic          done_o,
   output logic [AW-1:0] len_o,
   output logic [3:0]    stat_o,
   output logic          miss_o,
   output logic          busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DROP,
      S_DONE
   } state_t;

   localparam logic [31:0]   POLY    = 32'hEDB88320;
   localparam logic [31:0]   RESID   = 32'hDEBB20E3;
   localparam logic [7:0]    PRE_B   = 8'h55;
   localparam logic [7:0]    SFD_B   = 8'hD5;
   localparam logic [AW-1:0] CNT_MAX = '1;
   localparam logic [AW-1:0] MAX_C   = AW'(MAXLEN);
   localparam logic [AW-1:0] MIN_C   = AW'(MINLEN);
   localparam logic [AW-1:0] LAST_DA = AW'(5);

   state_t        state, state_nx;
   logic [AW-1:0] cnt;
   logic [31:0]   crc;
   logic          uc_ok, bc_ok;
   logic          rxer_f;
   logic          rxdv_q;
   logic [7:0]    mac_b;
   logic          uc_now, bc_now;
   logic          in_da, da_miss;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      mac_b = mac_i[47:40];
      case (cnt[2:0])
         3'd1:    mac_b = mac_i[39:32];
         3'd2:    mac_b = mac_i[31:24];
         3'd3:    mac_b = mac_i[23:16];
         3'd4:    mac_b = mac_i[15:8];
         3'd5:    mac_b = mac_i[7:0];
         default: mac_b = mac_i[47:40];
      endcase
   end

   // running match state includes the byte currently on dat_i
   assign in_da   = (cnt <= LAST_DA);
   assign uc_now  = uc_ok & (dat_i == mac_b);
   assign bc_now  = bc_ok & (dat_i == 8'hFF);
   assign da_miss = (cnt == LAST_DA) & ~promisc_i & ~uc_now & ~bc_now;

   assign busy_o = (state == S_PRE) | (state == S_DATA) |
                   (state == S_DROP);

   always_ff @(posedge rxclk_i or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (rxdv_i) state_nx = ena_i ? S_PRE : S_DROP;
         end
         S_PRE: begin
            if (!rxdv_i)               state_nx = S_IDLE;
            else if (dat_i == SFD_B)   state_nx = S_DATA;
            else if (dat_i != PRE_B)   state_nx = S_DROP;
         end
         S_DATA: begin
            if (!rxdv_i)
               state_nx = (cnt <= LAST_DA) ? S_IDLE : S_DONE;
            else if (da_miss)
               state_nx = S_DROP;
         end
         S_DROP: begin
            if (!rxdv_i) state_nx = S_IDLE;
         end
         S_DONE: begin
            if (ack_i) state_nx = rxdv_i ? S_DROP : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge rxclk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_o    <= 1'b0;
         waddr_o <= '0;
         wdat_o  <= '0;
         done_o  <= 1'b0;
         len_o   <= '0;
         stat_o  <= '0;
         miss_o  <= 1'b0;
         cnt     <= '0;
         crc     <= '1;
         uc_ok   <= 1'b0;
         bc_ok   <= 1'b0;
         rxer_f  <= 1'b0;
         rxdv_q  <= 1'b0;
      end else begin
         wr_o   <= 1'b0;
         miss_o <= 1'b0;
         rxdv_q <= rxdv_i;
         unique case (state)
            S_PRE: begin
               if (rxdv_i && dat_i == SFD_B) begin
                  cnt    <= '0;
                  crc    <= '1;
                  uc_ok  <= 1'b1;
                  bc_ok  <= 1'b1;
                  rxer_f <= 1'b0;
               end
            end
            S_DATA: begin
               if (rxdv_i) begin
                  wr_o    <= (cnt < MAX_C);
                  waddr_o <= cnt;
                  wdat_o  <= dat_i;
                  crc     <= crc_byte(crc, dat_i);
                  rxer_f  <= rxer_f | rxer_i;
                  if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                  if (in_da) begin
                     uc_ok <= uc_now;
                     bc_ok <= bc_now;
                  end
               end else if (cnt > LAST_DA) begin
                  done_o <= 1'b1;
                  len_o  <= cnt;
                  stat_o <= {rxer_f, (cnt > MAX_C),
                             (cnt < MIN_C), (crc != RESID)};
               end
            end
            S_DONE: begin
               if (ack_i)
                  done_o <= 1'b0;
               else if (rxdv_i && !rxdv_q)
                  miss_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_rxframe.sv
// Directed bench for eth_rxframe: RAM writes and reports are checked
// against scoreboard queues filled while frames are driven.
module tb_eth_rxframe;

   localparam int AW     = 11;
   localparam int MAXLEN = 1518;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rxdv = 1'b0;
   logic          rxer = 1'b0;
   logic [7:0]    dat = '0;
   logic          ena = 1'b1;
   logic          promisc = 1'b0;
   logic [47:0]   mac = 48'h02_11_22_33_44_01;
   logic          ack = 1'b0;
   logic          wr_o;
   logic [AW-1:0] waddr_o;
   logic [7:0]    wdat_o;
   logic          done_o;
   logic [AW-1:0] len_o;
   logic [3:0]    stat_o;
   logic          miss_o;
   logic          busy_o;

   int tests = 0;
   int fails = 0;
   int miss_cnt = 0;
   int m0;

   logic [7:0]      frm[$];
   logic [18:0]     wq[$];
   logic [14:0]     dq[$];
   logic [14:0]     held = '0;
   logic            done_q = 1'b0;

   always #5 clk = ~clk;

   eth_rxframe #(.AW(AW), .MAXLEN(MAXLEN), .MINLEN(64)) dut (
      .rxclk_i   (clk),
      .rst_n     (rst_n),
      .rxdv_i    (rxdv),
      .rxer_i    (rxer),
      .dat_i     (dat),
      .ena_i     (ena),
      .promisc_i (promisc),
      .mac_i     (mac),
      .ack_i     (ack),
      .wr_o      (wr_o),
      .waddr_o   (waddr_o),
      .wdat_o    (wdat_o),
      .done_o    (done_o),
      .len_o     (len_o),
      .stat_o    (stat_o),
      .miss_o    (miss_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] b);
      logic fb;
      for (int k = 0; k < 8; k++) begin
         fb = c[0] ^ b[k];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   task automatic build(input logic [47:0] dst, input int len,
                        input bit bad);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
      for (int i = 6; i < len - 4; i++) frm.push_back(8'(i * 13 + 1));
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_upd(c, frm[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
      if (bad) frm[len-1] = frm[len-1] ^ 8'hFF;
   endtask

   function automatic logic [37:0] all_outs();
      return {wr_o, waddr_o, wdat_o, done_o, len_o, stat_o,
              miss_o, busy_o};
   endfunction

   // nwr: bytes expected in RAM; rst_at: byte index pulsing reset
   task automatic send(input int nwr, input int rst_at,
                       input bit ack_first);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rxdv = 1'b1;
         dat  = (i == 7) ? 8'hD5 : 8'h55;
         ack  = ack_first && (i == 0);
      end
      for (int i = 0; i < frm.size(); i++) begin
         @(negedge clk);
         dat = frm[i];
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1 chk("rst_mid_outs", all_outs(), '0);
         end else begin
            rst_n = 1'b1;
            if (i < nwr) wq.push_back({11'(i), frm[i]});
         end
      end
      @(negedge clk);
      rxdv  = 1'b0;
      rst_n = 1'b1;
      dat   = '0;
   endtask

   task automatic end_chk(input string tag, input bit exp_done);
      @(posedge clk);
      #1 chk(tag, done_o, exp_done);
      if (!exp_done) chk({tag, "_busy"}, busy_o, 1'b0);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1 chk("ack_done", done_o, 1'b0);
      @(negedge clk);
      ack = 1'b0;
   endtask

   always @(posedge clk) begin
      logic [18:0] ew;
      logic [14:0] ed;
      #3;
      if (wr_o) begin
         ew = (wq.size() > 0) ? wq.pop_front() : 'x;
         chk("ram_wr", {waddr_o, wdat_o}, ew);
      end
      if (done_o && !done_q) begin
         ed = (dq.size() > 0) ? dq.pop_front() : 'x;
         held = ed;
         chk("done_rpt", {len_o, stat_o}, ed);
      end else if (done_o) begin
         chk("done_hold", {len_o, stat_o}, held);
      end
      done_q = done_o;
      if (miss_o) miss_cnt++;
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", all_outs(), '0);
      rst_n = 1'b1;

      build(mac, 64, 1'b0);
      dq.push_back({11'd64, 4'b0000});
      send(64, -1, 1'b0);
      end_chk("uni_done", 1'b1);
      do_ack();

      build(mac, 64, 1'b1);
      dq.push_back({11'd64, 4'b0001});
      send(64, -1, 1'b0);
      end_chk("badfcs_done", 1'b1);
      do_ack();

      build(48'hFFFF_FFFF_FFFF, 60, 1'b0);
      dq.push_back({11'd60, 4'b0010});
      send(60, -1, 1'b0);
      end_chk("bcast_done", 1'b1);
      do_ack();

      build(48'h02_11_22_33_44_99, 64, 1'b0);
      send(6, -1, 1'b0);
      end_chk("filt_done", 1'b0);

      promisc = 1'b1;
      dq.push_back({11'd64, 4'b0000});
      send(64, -1, 1'b0);
      end_chk("promisc_done", 1'b1);
      do_ack();
      promisc = 1'b0;

      build(mac, 70, 1'b0);
      dq.push_back({11'd70, 4'b0000});
      send(70, -1, 1'b0);
      end_chk("pend_done", 1'b1);
      m0 = miss_cnt;
      send(0, -1, 1'b0);
      end_chk("miss_done", 1'b1);
      chk("miss_pulses", miss_cnt - m0, 1);
      chk("miss_len", len_o, 11'd70);
      chk("miss_stat", stat_o, 4'b0000);

      m0 = miss_cnt;
      send(0, -1, 1'b1);
      end_chk("ackstart_done", 1'b0);
      chk("ackstart_miss", miss_cnt - m0, 0);

      build(mac, 64, 1'b0);
      send(20, 20, 1'b0);
      end_chk("rst_done", 1'b0);

      dq.push_back({11'd64, 4'b0000});
      send(64, -1, 1'b0);
      end_chk("after_rst_done", 1'b1);
      do_ack();

      build(mac, 1520, 1'b0);
      dq.push_back({11'd1520, 4'b0100});
      send(MAXLEN, -1, 1'b0);
      end_chk("long_done", 1'b1);
      do_ack();

      repeat (3) @(negedge clk);
      chk("wq_empty", wq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
